// File: rtl/hoplite_rt_router_ctrl_pkg.sv
// Shared definitions for the Hoplite-RT switch controller: switch-mux select
// encodings and the deflection counter ceiling.
package hoplite_rt_router_ctrl_pkg;

    // 3:2 switch mux select: which input feeds East / South
    typedef enum logic [1:0] {
        SEL_WN  = 2'b00,  // E=W,  S=N
        SEL_NW  = 2'b01,  // E=N,  S=W
        SEL_PEN = 2'b10,  // E=PE, S=N
        SEL_WPE = 2'b11   // E=W,  S=PE
    } sel_e;

    localparam logic [15:0] DEFLECT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == DEFLECT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hoplite_rt_router_ctrl_regulator.sv
// Token-bucket injection regulator: one token every RATE cycles, bucket depth
// BURST. RATE==0 disables regulation (tok_ok always high).
module hoplite_rt_regulator #(
    parameter int RATE  = 4,
    parameter int BURST = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic consume,
    output logic tok_ok
);

    localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int TW = $clog2(BURST + 1);
    localparam logic [CW-1:0] CTR_LAST = CW'((RATE > 0) ? RATE - 1 : 0);
    localparam logic [TW-1:0] TOK_MAX  = TW'(BURST);

    logic [CW-1:0] ctr_q, ctr_d;
    logic [TW-1:0] tok_q, tok_d;
    logic          repl;

    assign repl   = (RATE != 0) && (ctr_q == CTR_LAST);
    assign tok_ok = (RATE == 0) || (tok_q != '0);

    // A replenish and a consume in the same cycle cancel out
    always_comb begin
        ctr_d = repl ? '0 : ctr_q + CW'(1);
        tok_d = tok_q;
        if (repl && !consume && (tok_q != TOK_MAX)) begin
            tok_d = tok_q + TW'(1);
        end else if (consume && !repl && (tok_q != '0)) begin
            tok_d = tok_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctr_q <= '0;
            tok_q <= TOK_MAX;
        end else begin
            ctr_q <= ctr_d;
            tok_q <= tok_d;
        end
    end

endmodule

// File: rtl/hoplite_rt_router_ctrl.sv
// Hoplite-RT per-node switch controller: DOR routing with N-over-W priority,
// West deflection to East, local ejection and rate-regulated PE injection.
module hoplite_rt_router_ctrl
    import hoplite_rt_router_ctrl_pkg::*;
#(
    parameter int P_W   = 32,
    parameter int X_W   = 2,
    parameter int Y_W   = 2,
    parameter int MY_X  = 0,
    parameter int MY_Y  = 0,
    parameter int RATE  = 4,
    parameter int BURST = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [P_W-1:0] in_w,
    input  logic [P_W-1:0] in_n,
    input  logic [P_W-1:0] pe_in,
    input  logic           pe_in_valid,
    output logic           pe_in_ready,
    output logic [P_W-1:0] out_e,
    output logic [P_W-1:0] out_s,
    output logic [P_W-1:0] pe_out,
    output logic [15:0]    deflect_cnt
);

    localparam int VALID_B = P_W - 1;
    localparam int X_LSB   = P_W - 1 - X_W;
    localparam int Y_LSB   = X_LSB - Y_W;
    localparam logic [X_W-1:0] MY_XV = X_W'(MY_X);
    localparam logic [Y_W-1:0] MY_YV = Y_W'(MY_Y);

    logic           wv, nv, w_want_e, pe_want_e;
    logic           slot_free, tok_ok, inject, deflect, s_local;
    sel_e           base_sel, inj_sel, sel;
    logic [P_W-1:0] e_pkt, s_pkt;
    logic [P_W-1:0] out_e_q, out_e_d, out_s_q, out_s_d, pe_out_q, pe_out_d;
    logic [15:0]    dcnt_q, dcnt_d;

    assign wv        = in_w[VALID_B];
    assign nv        = in_n[VALID_B];
    assign w_want_e  = wv && (in_w[X_LSB +: X_W] != MY_XV);
    assign pe_want_e = (pe_in[X_LSB +: X_W] != MY_XV);

    // Slot analysis: base select without injection, and the select an injection would use
    always_comb begin
        base_sel  = SEL_WN;
        inj_sel   = SEL_WN;
        slot_free = 1'b0;
        deflect   = 1'b0;
        if (nv) begin
            inj_sel   = SEL_PEN;
            slot_free = !wv && pe_want_e;
            deflect   = wv && !w_want_e;
        end else if (wv) begin
            if (w_want_e) begin
                inj_sel   = SEL_WPE;
                slot_free = !pe_want_e;
            end else begin
                base_sel  = SEL_NW;
            end
        end else begin
            inj_sel   = pe_want_e ? SEL_PEN : SEL_WPE;
            slot_free = 1'b1;
        end
    end

    assign pe_in_ready = rst_n && slot_free && tok_ok;
    assign inject      = pe_in_valid && pe_in_ready;
    assign sel         = inject ? inj_sel : base_sel;

    always_comb begin
        e_pkt = in_w;
        s_pkt = in_n;
        case (sel)
            SEL_WN:  begin e_pkt = in_w;  s_pkt = in_n;  end
            SEL_NW:  begin e_pkt = in_n;  s_pkt = in_w;  end
            SEL_PEN: begin e_pkt = pe_in; s_pkt = in_n;  end
            SEL_WPE: begin e_pkt = in_w;  s_pkt = pe_in; end
            default: begin e_pkt = in_w;  s_pkt = in_n;  end
        endcase
    end

    assign s_local = s_pkt[VALID_B] && (s_pkt[X_LSB +: X_W] == MY_XV)
                     && (s_pkt[Y_LSB +: Y_W] == MY_YV);

    always_comb begin
        out_e_d  = e_pkt;
        out_s_d  = s_pkt;
        pe_out_d = '0;
        if (s_local) begin
            out_s_d[VALID_B] = 1'b0;
            pe_out_d         = s_pkt;
        end
        dcnt_d = deflect ? sat_inc16(dcnt_q) : dcnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_e_q  <= '0;
            out_s_q  <= '0;
            pe_out_q <= '0;
            dcnt_q   <= '0;
        end else begin
            out_e_q  <= out_e_d;
            out_s_q  <= out_s_d;
            pe_out_q <= pe_out_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign out_e       = out_e_q;
    assign out_s       = out_s_q;
    assign pe_out      = pe_out_q;
    assign deflect_cnt = dcnt_q;

    hoplite_rt_regulator #(
        .RATE  (RATE),
        .BURST (BURST)
    ) u_regulator (
        .clk     (clk),
        .rst_n   (rst_n),
        .consume (inject),
        .tok_ok  (tok_ok)
    );

endmodule

// File: tb/tb_hoplite_rt_router_ctrl.sv
// Scoreboard bench for hoplite_rt_router_ctrl at node (1,2), RATE=4, BURST=2.
module tb_hoplite_rt_router_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_w, in_n, pe_in;
    logic        pe_in_valid;
    logic        pe_in_ready;
    logic [31:0] out_e, out_s, pe_out;
    logic [15:0] deflect_cnt;

    always #5 clk = ~clk;

    hoplite_rt_router_ctrl #(
        .P_W(32), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(2), .RATE(4), .BURST(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_w        (in_w),
        .in_n        (in_n),
        .pe_in       (pe_in),
        .pe_in_valid (pe_in_valid),
        .pe_in_ready (pe_in_ready),
        .out_e       (out_e),
        .out_s       (out_s),
        .pe_out      (pe_out),
        .deflect_cnt (deflect_cnt)
    );

    typedef struct packed {
        logic [31:0] e;
        logic [31:0] s;
        logic [31:0] pe;
        logic [15:0] dc;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] dc_exp   = 16'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    function automatic logic [31:0] pkt(input int x, input int y, input int pl);
        logic [31:0] p;
        p = {1'b1, 2'(x), 2'(y), 27'(pl)};
        return p;
    endfunction

    function automatic logic [31:0] clr_v(input logic [31:0] p);
        logic [31:0] r;
        r     = p;
        r[31] = 1'b0;
        return r;
    endfunction

    // Output monitor: each registered result appears one edge after its inputs
    always @(posedge clk) begin
        exp_t  x;
        string t;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, "/out_e"},  out_e,  x.e);
            chk({t, "/out_s"},  out_s,  x.s);
            chk({t, "/pe_out"}, pe_out, x.pe);
            chk({t, "/dcnt"},   {16'h0, deflect_cnt}, {16'h0, x.dc});
        end
    end

    // Drive one cycle of inputs; rdy < 0 skips the ready check
    task automatic step(input string tag, input logic rn,
                        input logic [31:0] w, input logic [31:0] n,
                        input logic [31:0] pe, input logic pv, input int rdy,
                        input logic [31:0] xe, input logic [31:0] xs,
                        input logic [31:0] xpe);
        exp_t x;
        @(negedge clk);
        rst_n       = rn;
        in_w        = w;
        in_n        = n;
        pe_in       = pe;
        pe_in_valid = pv;
        #1;
        if (rdy >= 0) chk({tag, "/ready"}, {31'b0, pe_in_ready}, 32'(rdy));
        x.e  = xe;
        x.s  = xs;
        x.pe = xpe;
        x.dc = dc_exp;
        exp_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    initial begin
        logic [31:0] w, n, p;
        int          k;
        logic        acc;

        rst_n       = 1'b0;
        in_w        = '0;
        in_n        = '0;
        pe_in       = '0;
        pe_in_valid = 1'b0;

        // Reset with every input valid
        dc_exp = 16'd0;
        step("rst0", 1'b0, pkt(3,0,11), pkt(1,3,22), pkt(3,0,33), 1'b1, 0, '0, '0, '0);
        step("rst1", 1'b0, pkt(3,0,11), pkt(1,3,22), pkt(3,0,33), 1'b1, 0, '0, '0, '0);

        w = pkt(3,0,'h101);
        step("w_east", 1'b1, w, '0, pkt(3,0,'h102), 1'b1, 0, w, '0, '0);

        w = pkt(1,0,'h201); n = pkt(1,3,'h202);
        dc_exp = 16'd1;
        step("deflect", 1'b1, w, n, '0, 1'b0, 0, w, n, '0);

        n = pkt(1,2,'h301);
        step("eject_n", 1'b1, '0, n, '0, 1'b0, 1, '0, clr_v(n), n);

        w = pkt(1,0,'h401);
        step("w_turn", 1'b1, w, '0, pkt(1,3,'h402), 1'b1, 0, '0, w, '0);

        w = pkt(1,2,'h501);
        step("w_turn_ej", 1'b1, w, '0, '0, 1'b0, 0, '0, clr_v(w), w);

        n = pkt(1,0,'h601); p = pkt(3,1,'h602);
        step("inj_e", 1'b1, '0, n, p, 1'b1, 1, p, n, '0);

        w = pkt(2,1,'h701); p = pkt(1,2,'h702);
        step("inj_s_ej", 1'b1, w, '0, p, 1'b1, 1, w, clr_v(p), p);

        step("tok_empty", 1'b1, '0, '0, pkt(3,0,'h801), 1'b1, 0, '0, '0, '0);

        w = pkt(3,3,'h901);
        step("pre_rst", 1'b1, w, '0, '0, 1'b0, 0, w, '0, '0);

        // Reset mid-operation clears registered packets and the counter
        dc_exp = 16'd0;
        step("rst_mid0", 1'b0, pkt(3,3,'hA01), pkt(1,1,'hA02), '0, 1'b0, -1, '0, '0, '0);
        step("rst_mid1", 1'b0, '0, '0, '0, 1'b0, -1, '0, '0, '0);

        // Idle network, continuous injection request: burst of 2 then 1 per 4 cycles
        k = 0;
        for (int i = 0; i < 12; i++) begin
            p   = pkt(3,0,'hB00 + k);
            acc = (i == 0) || (i == 1) || (i == 4) || (i == 8);
            step($sformatf("reg%0d", i), 1'b1, '0, '0, p, 1'b1, acc ? 1 : 0,
                 acc ? p : '0, '0, '0);
            if (acc) k++;
        end

        step("idle", 1'b1, '0, '0, '0, 1'b0, 1, '0, '0, '0);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
